chua_stream_gen: RTL
====================

Name: chua_stream_gen

Overview:
- Parametrised fixed-point iterator for the discretised Chua chaotic system, using shift-add arithmetic only (no multipliers).
- Seeds are loaded over a valid/ready handshake and a configurable warm-up is discarded.
- One (x,y,z) sample is emitted every STEP iterations on a valid/ready output stream, with back-pressure stall.
- Overflow is detected and handled by saturation or fault. The block sits as a chaos-based entropy/stimulus source feeding downstream consumers.

Parameters:
- W, 32, total state word width (signed two's complement).
- FRAC, 28, fractional bits; INT_W = W-FRAC (incl. sign), range [-2^(INT_W-1), 2^(INT_W-1)).
- SH_X, 1, right-shift step for x update.
- SH_Y, 4, right-shift step for y update.
- SH_Z, 0, right-shift applied to y in z update.
- STEP, 1, iterations per emitted sample (>=1).
- WARMUP, 0, iterations discarded after each seed load (0..2^16-1).
- SAT, 0, 1 = saturate on overflow, 0 = enter FAULT.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, synchronous, active-high.
- run_en, input, 1, iteration enable; low freezes state and counters.
- seed_valid, input, 1, seed offered.
- seed_ready, output, 1, seed accepted when high with seed_valid.
- seed_x / seed_y / seed_z, input, W, initial state.
- out_valid, output, 1, sample available.
- out_ready, input, 1, consumer accepts sample.
- out_x / out_y / out_z, output, W, sample state.
- fault, output, 1, overflow with SAT=0; sticky until seed load.
- sat_flag, output, 1, sticky: saturation occurred (SAT=1); cleared on seed load.
- iter_count, output, 32, iterations since last seed load, wraps at 2^32.

Behaviour:
- Reset: all outputs and state registers go to 0; FSM enters IDLE; seed_ready=1.
- FSM states: IDLE, WARM, RUN, HOLD, FAULT. seed_ready=1 in every state, so a seed load always takes priority.
- Seed accept in cycle t:
  - x,y,z loaded at edge t; iter_count, fault, sat_flag cleared; out_valid=0.
  - Next state is WARM if WARMUP>0, else RUN.
- Iteration: one per cycle when run_en=1 and state is WARM or RUN. All right-hand sides use old values.
  - Let one = 2^FRAC and C = one>>3.
  - inner = (x >= -one) && (x < one).
  - f = inner ? (x>>>2) : ((x>>>3) + (x>=0 ? C : -C)); f is continuous at |x|=1.
  - x' = x + ((y - f) >>> SH_X)
  - y' = y + ((x - y + z) >>> SH_Y)
  - z' = z - (y >>> SH_Z)
  - Intermediates are computed at W+3 bits; >>> is arithmetic (floor).
- Overflow: a result outside the W-bit range.
  - SAT=1: clamp to max/min, set sat_flag, continue.
  - SAT=0: state registers unchanged; fault=1 at the same edge; go to FAULT.
- WARM: counts WARMUP iterations, then goes to RUN. No samples are emitted in WARM.
- RUN:
  - A step counter counts iterations.
  - On the STEP-th iteration, the new state is registered into both the state registers and out_*; out_valid=1; go to HOLD.
- HOLD: iteration halted. On out_valid && out_ready, out_valid=0 next cycle and return to RUN. No samples are dropped or duplicated.
- out_* are stable while out_valid=1 and not yet accepted.
- Sustained throughput: STEP=1 with out_ready held high gives one sample per 2 cycles (a RUN cycle plus a HOLD handshake cycle).
- FAULT: out_valid=0; only a seed load or rst exits it.
- Seed load during HOLD: the pending sample is discarded (out_valid=0).
- run_en=0: counters and state are frozen; HOLD handshakes still complete.
- Reset mid-operation: everything returns to reset values at that edge.

Decomposition:
- Package chua_pkg: FSM state enum; fixed-point helper constants (ONE, C = ONE>>3) as functions of W/FRAC; saturate/overflow-check function.
- Sub-module chua_step: purely combinational iteration datapath. Inputs x,y,z; outputs x',y',z' and an ovf flag. Parameters W, FRAC, SH_*, SAT.
- Top module holds the FSM, counters, and output registers.

Test Plan (W=32, FRAC=28, defaults unless stated):
- Inner region: seed x=0x08000000, y=z=0, out_ready=1 -> first sample x=0x07000000, y=0x00800000, z=0; iter_count=1.
- Outer region:
  - seed x=0x20000000, y=z=0 -> sample x=0x1D000000, y=0x02000000, z=0.
  - seed x=0xE0000000 -> sample x=0xE3000000, y=0xFE000000.
- Fixed point: seed all 0, run 100 iterations -> every sample is 0, fault=0.
- Back-pressure:
  - Hold out_ready=0 for 10 cycles -> out_* stable, iter_count frozen.
  - Release out_ready -> exactly one accept, then iteration resumes.
- Warm-up/step: WARMUP=3, STEP=2 -> first out_valid shows iter_count=5; next sample at iter_count=7.
- Overflow:
  - SAT=0, seed x=y=0x78000000, z=0 -> fault=1 after 1 iteration, out_valid stays 0; new seed clears fault.
  - SAT=1, same seed -> x'=0x7FFFFFFF, sat_flag=1.

Source files
------------

// File: rtl/chua_pkg.sv
// Shared types and fixed-point helpers for the Chua stream generator.
// The helpers work on 64-bit values, so the state width W must be 61 or less.
package chua_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WARM  = 3'd1,
    ST_RUN   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } chua_state_t;

  function automatic logic signed [63:0] fx_one(input int frac);
    return 64'sd1 <<< frac;
  endfunction

  function automatic logic signed [63:0] fx_c(input int frac);
    return fx_one(frac) >>> 3;
  endfunction

  function automatic logic signed [63:0] fx_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] fx_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic fx_ovf(input logic signed [63:0] v, input int w);
    return (v > fx_max(w)) || (v < fx_min(w));
  endfunction

  function automatic logic signed [63:0] fx_sat(input logic signed [63:0] v, input int w);
    if (v > fx_max(w)) return fx_max(w);
    if (v < fx_min(w)) return fx_min(w);
    return v;
  endfunction

endpackage

// File: rtl/chua_stream_gen_step.sv
// Combinational Chua iteration: one shift-add update of (x,y,z) with an overflow flag.
// The arithmetic runs at W+3 bits so that no intermediate can wrap.
module chua_step
  import chua_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 28,
  parameter int SH_X = 1,
  parameter int SH_Y = 4,
  parameter int SH_Z = 0,
  parameter int SAT  = 0
) (
  input  logic signed [W-1:0] i_x,
  input  logic signed [W-1:0] i_y,
  input  logic signed [W-1:0] i_z,
  output logic signed [W-1:0] o_x,
  output logic signed [W-1:0] o_y,
  output logic signed [W-1:0] o_z,
  output logic                o_ovf
);

  localparam int WE = W + 3;
  localparam logic signed [WE-1:0] ONE = WE'(fx_one(FRAC));
  localparam logic signed [WE-1:0] C   = WE'(fx_c(FRAC));

  logic signed [WE-1:0] w_x, w_y, w_z, w_f;
  logic signed [WE-1:0] w_xn, w_yn, w_zn;
  logic                 w_inner;

  always_comb begin
    w_x     = WE'(i_x);
    w_y     = WE'(i_y);
    w_z     = WE'(i_z);
    w_inner = (w_x >= -ONE) && (w_x < ONE);
    // Outer slope 1/8 with offset C keeps f continuous at |x| = 1.
    w_f     = w_inner ? (w_x >>> 2) : ((w_x >>> 3) + (w_x[WE-1] ? -C : C));
    w_xn    = w_x + ((w_y - w_f) >>> SH_X);
    w_yn    = w_y + ((w_x - w_y + w_z) >>> SH_Y);
    w_zn    = w_z - (w_y >>> SH_Z);
  end

  always_comb begin
    o_ovf = fx_ovf(64'(w_xn), W) || fx_ovf(64'(w_yn), W) || fx_ovf(64'(w_zn), W);
    if (SAT != 0) begin
      o_x = W'(fx_sat(64'(w_xn), W));
      o_y = W'(fx_sat(64'(w_yn), W));
      o_z = W'(fx_sat(64'(w_zn), W));
    end else begin
      o_x = w_xn[W-1:0];
      o_y = w_yn[W-1:0];
      o_z = w_zn[W-1:0];
    end
  end

endmodule

// File: rtl/chua_stream_gen.sv
// Chua chaotic stream source: seed load, warm-up discard, one sample every STEP
// iterations on a valid/ready stream, with overflow saturation or fault.
module chua_stream_gen
  import chua_pkg::*;
#(
  parameter int W      = 32,
  parameter int FRAC   = 28,
  parameter int SH_X   = 1,
  parameter int SH_Y   = 4,
  parameter int SH_Z   = 0,
  parameter int STEP   = 1,
  parameter int WARMUP = 0,
  parameter int SAT    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run_en,
  input  logic                seed_valid,
  output logic                seed_ready,
  input  logic signed [W-1:0] seed_x,
  input  logic signed [W-1:0] seed_y,
  input  logic signed [W-1:0] seed_z,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_x,
  output logic signed [W-1:0] out_y,
  output logic signed [W-1:0] out_z,
  output logic                fault,
  output logic                sat_flag,
  output logic [31:0]         iter_count
);

  localparam logic [15:0] WARM_LAST = (WARMUP > 0) ? 16'(WARMUP - 1) : 16'd0;
  localparam logic [31:0] STEP_LAST = 32'(STEP - 1);

  chua_state_t r_state, w_next;

  logic signed [W-1:0] r_x, r_y, r_z;
  logic signed [W-1:0] r_out_x, r_out_y, r_out_z;
  logic signed [W-1:0] w_xn, w_yn, w_zn;
  logic                w_ovf;
  logic [15:0]         r_warm_cnt;
  logic [31:0]         r_step_cnt;
  logic [31:0]         r_iter;
  logic                r_out_valid, r_fault, r_sat;
  logic                w_iter, w_fault_now, w_commit, w_warm_done, w_emit, w_accept;

  chua_step #(
    .W(W), .FRAC(FRAC), .SH_X(SH_X), .SH_Y(SH_Y), .SH_Z(SH_Z), .SAT(SAT)
  ) u_step (
    .i_x(r_x), .i_y(r_y), .i_z(r_z),
    .o_x(w_xn), .o_y(w_yn), .o_z(w_zn),
    .o_ovf(w_ovf)
  );

  // A seed offer always wins, so no iteration happens in the cycle it is accepted.
  always_comb begin
    w_iter      = run_en && !seed_valid && ((r_state == ST_WARM) || (r_state == ST_RUN));
    w_fault_now = w_iter && w_ovf && (SAT == 0);
    w_commit    = w_iter && !w_fault_now;
    w_warm_done = (r_state == ST_WARM) && (r_warm_cnt == WARM_LAST);
    w_emit      = w_commit && (r_state == ST_RUN) && (r_step_cnt == STEP_LAST);
    w_accept    = (r_state == ST_HOLD) && r_out_valid && out_ready;
  end

  always_comb begin
    w_next = r_state;
    if (seed_valid) begin
      w_next = (WARMUP > 0) ? ST_WARM : ST_RUN;
    end else begin
      case (r_state)
        ST_WARM, ST_RUN: begin
          if (w_fault_now)                 w_next = ST_FAULT;
          else if (w_commit && w_warm_done) w_next = ST_RUN;
          else if (w_emit)                 w_next = ST_HOLD;
        end
        ST_HOLD: if (w_accept) w_next = ST_RUN;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_z     <= '0;
      r_out_valid <= 1'b0;
      r_fault     <= 1'b0;
      r_sat       <= 1'b0;
      r_iter      <= '0;
      r_warm_cnt  <= '0;
      r_step_cnt  <= '0;
    end else if (seed_valid) begin
      r_x         <= seed_x;
      r_y         <= seed_y;
      r_z         <= seed_z;
      r_out_valid <= 1'b0;
      r_fault     <= 1'b0;
      r_sat       <= 1'b0;
      r_iter      <= '0;
      r_warm_cnt  <= '0;
      r_step_cnt  <= '0;
    end else begin
      if (w_commit) begin
        r_x    <= w_xn;
        r_y    <= w_yn;
        r_z    <= w_zn;
        r_iter <= r_iter + 32'd1;
        if (w_ovf) r_sat <= 1'b1;
        if (r_state == ST_WARM) r_warm_cnt <= r_warm_cnt + 16'd1;
        if (r_state == ST_RUN)
          r_step_cnt <= (r_step_cnt == STEP_LAST) ? 32'd0 : r_step_cnt + 32'd1;
      end
      if (w_fault_now) r_fault <= 1'b1;
      if (w_emit) begin
        r_out_x     <= w_xn;
        r_out_y     <= w_yn;
        r_out_z     <= w_zn;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign seed_ready = 1'b1;
  assign out_valid  = r_out_valid;
  assign out_x      = r_out_x;
  assign out_y      = r_out_y;
  assign out_z      = r_out_z;
  assign fault      = r_fault;
  assign sat_flag   = r_sat;
  assign iter_count = r_iter;

endmodule
